// File: rtl/data_ram_hs_if.sv
// Request/response bundle for the handshaked data RAM.
// The master drives the request side; the slave returns status and data.
interface data_ram_hs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int LANES = DATA_W / 8;

    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LANES-1:0]  sel_i;
    logic [DATA_W-1:0] data_i;
    logic              busy_o;
    logic              ack_o;
    logic              err_o;
    logic [DATA_W-1:0] data_o;
    logic              mmio_valid_o;
    logic [7:0]        mmio_data_o;

    modport master (
        output req_i, we_i, addr_i, sel_i, data_i,
        input  busy_o, ack_o, err_o, data_o, mmio_valid_o, mmio_data_o
    );

    modport slave (
        input  req_i, we_i, addr_i, sel_i, data_i,
        output busy_o, ack_o, err_o, data_o, mmio_valid_o, mmio_data_o
    );
endinterface

// File: rtl/data_ram_hs.sv
// Byte-lane data RAM with req/ack handshake, programmable wait states,
// out-of-range error reporting and a registered console byte port.
module data_ram_hs #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_ADDR   = 32'h104
) (
    input logic          clk,
    input logic          rst,
    data_ram_hs_if.slave bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int LB     = $clog2(LANES);
    localparam int IDX_W  = ADDR_W - LB;
    localparam int MEM_AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0]       WLOAD     = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] MMIO_IDX  = IDX_W'(MMIO_ADDR >> LB);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    logic [LANES-1:0][7:0] mem [DEPTH];

    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   oor_q, oor_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LANES-1:0]       sel_q, sel_d;
    logic [LANES-1:0][7:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   mv_q, mv_d;
    logic [7:0]             md_q, md_d;

    logic [IDX_W-1:0] in_idx, acc_idx;
    logic             acc_we, acc_oor;

    always_comb begin
        in_idx  = bus.addr_i[ADDR_W-1:LB];
        // With zero wait states the read happens on the accepting edge,
        // so the live request must be used instead of the captured copy.
        acc_idx = (state_q == S_IDLE) ? in_idx   : idx_q;
        acc_we  = (state_q == S_IDLE) ? bus.we_i : we_q;
        acc_oor = (acc_idx >= DEPTH_IDX);

        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        mv_d    = 1'b0;
        md_d    = md_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    idx_d   = in_idx;
                    we_d    = bus.we_i;
                    sel_d   = bus.sel_i;
                    wdata_d = bus.data_i;
                    oor_d   = acc_oor;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WLOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (we_q && sel_q[0] && !oor_q && idx_q == MMIO_IDX) begin
                    mv_d = 1'b1;
                    md_d = wdata_q[0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RESP && state_q != S_RESP && !acc_we)
            data_d = acc_oor ? '0 : mem[acc_idx[MEM_AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            mv_q    <= 1'b0;
            md_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
        end
    end

    // Storage is never cleared; a reset drops the FSM to IDLE so no commit occurs.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !oor_q) begin
            for (int k = 0; k < LANES; k++)
                if (sel_q[k]) mem[idx_q[MEM_AW-1:0]][k] <= wdata_q[k];
        end
    end

    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.ack_o        = (state_q == S_RESP);
    assign bus.err_o        = (state_q == S_RESP) && oor_q;
    assign bus.data_o       = data_q;
    assign bus.mmio_valid_o = mv_q;
    assign bus.mmio_data_o  = md_q;
endmodule
